// File: rtl/operand_serializer.sv
// operand_serializer: parallel-in, serial-out operand shifter for the
// sequential multiplier datapath. Captures a WIDTH-bit operand on load,
// then emits one bit per Shift strobe on Data_Out and pulses done once
// the last bit has been consumed.
//
// Optional build macro: SERIALIZER_MSB_FIRST_EN
//   defined     -> MSB first, left shift with zero fill at the LSB
//   not defined -> LSB first, right shift with zero fill at the MSB
// Timing, counting and done behaviour are identical in both builds.
module operand_serializer #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] Data_In,
   input  logic             Shift,
   output logic             Data_Out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_count
);

`ifdef SERIALIZER_MSB_FIRST_EN
   localparam int unsigned OUT_IDX = WIDTH - 1;
`else
   localparam int unsigned OUT_IDX = 0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // State, shift register and registered status outputs; reset aborts any transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         sreg      <= '0;
         bit_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bit_count <= cnt_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Next-state logic: load is only honoured outside SHIFT, last Shift moves to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (load) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (Shift && (bit_count == CNT_W'(1))) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = load ? ST_SHIFT : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath and status next values; busy/done mirror the state being entered.
   always_comb begin
      sreg_nxt = sreg;
      cnt_nxt  = bit_count;
      busy_nxt = (state_nxt == ST_SHIFT);
      done_nxt = (state_nxt == ST_DONE);
      case (state)
         ST_IDLE, ST_DONE: begin
            if (load) begin
               sreg_nxt = Data_In;
               cnt_nxt  = CNT_W'(WIDTH);
            end else begin
               cnt_nxt  = '0;
            end
         end
         ST_SHIFT: begin
            // Counter guard keeps bit_count from ever wrapping below zero.
            if (Shift && (bit_count != '0)) begin
`ifdef SERIALIZER_MSB_FIRST_EN
               sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
`else
               sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
`endif
               cnt_nxt  = bit_count - CNT_W'(1);
            end
         end
         default: begin
            sreg_nxt = '0;
            cnt_nxt  = '0;
         end
      endcase
   end

   // Serial bit is only driven while shifting; the consumer samples it on the Shift edge.
   assign Data_Out = (state == ST_SHIFT) ? sreg[OUT_IDX] : 1'b0;

endmodule

// File: tb/tb_operand_serializer.sv
// Testbench for operand_serializer: directed scenarios plus random traffic.
// The driver predicts accepted operands and pushes their expected bit stream
// into a scoreboard; a negedge monitor checks every DUT output against it.
module tb_operand_serializer;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk;
   logic          rst;
   logic          load;
   logic [W-1:0]  Data_In;
   logic          Shift;
   logic          Data_Out;
   logic          busy;
   logic          done;
   logic [CW-1:0] bit_count;

   operand_serializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .Data_In   (Data_In),
      .Shift     (Shift),
      .Data_Out  (Data_Out),
      .busy      (busy),
      .done      (done),
      .bit_count (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic b;
      int   rem;
   } item_t;

   item_t sb[$];
   int    n_tests  = 0;
   int    n_fail   = 0;
   bit    mon_en   = 1'b0;
   bit    done_pend = 1'b0;
   int    ref_left = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference: an accepted operand becomes W bits in output order, W..1 remaining.
   task automatic push_operand(input logic [W-1:0] d);
      item_t it;
      for (int k = 0; k < int'(W); k++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
         it.b = d[int'(W) - 1 - k];
`else
         it.b = d[k];
`endif
         it.rem = int'(W) - k;
         sb.push_back(it);
      end
   endtask

   // One clock: apply inputs, wait for the edge, advance the reference.
   task automatic cycle(input logic r, input logic ld, input logic [W-1:0] d, input logic sh);
      rst     = r;
      load    = ld;
      Data_In = d;
      Shift   = sh;
      @(posedge clk);
      if (!r) begin
         ref_left  = 0;
         sb.delete();
         done_pend = 1'b0;
      end else if (ref_left == 0) begin
         if (ld) begin
            ref_left = int'(W);
            push_operand(d);
         end
      end else if (sh) begin
         ref_left--;
      end
      #1;
   endtask

   // Monitor: compare outputs mid-cycle, then retire the bit consumed at the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0) begin
            chk("busy", int'(busy), 1);
            chk("bit_count", int'(bit_count), sb[0].rem);
            chk("data_out", int'(Data_Out), int'(sb[0].b));
         end else begin
            chk("busy", int'(busy), 0);
            chk("bit_count", int'(bit_count), 0);
            chk("data_out", int'(Data_Out), 0);
         end
         chk("done", int'(done), int'(done_pend));
         done_pend = 1'b0;
         if (rst && Shift && (sb.size() > 0)) begin
            if (sb[0].rem == 1) done_pend = 1'b1;
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      logic [3:0] pat;
      rst = 1'b0; load = 1'b0; Data_In = '0; Shift = 1'b0;

      // Reset state
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      mon_en = 1'b1;

      // Shift in IDLE has no effect
      repeat (3) cycle(1'b1, 1'b0, '0, 1'b1);

      // Basic stream, Shift held high
      cycle(1'b1, 1'b1, 8'hB5, 1'b0);
      repeat (W) cycle(1'b1, 1'b0, '0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);

      // Stalled Shift pattern 1,0,0,1
      pat = 4'b1001;
      cycle(1'b1, 1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < 2 * int'(W); i++) cycle(1'b1, 1'b0, '0, pat[i % 4]);
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);

      // load during SHIFT ignored
      cycle(1'b1, 1'b1, 8'h01, 1'b0);
      repeat (W) cycle(1'b1, 1'b1, 8'hFF, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);

      // Back-to-back: load in the DONE cycle
      cycle(1'b1, 1'b1, 8'h96, 1'b0);
      repeat (W) cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b1, 8'hA5, 1'b0);
      repeat (W) cycle(1'b1, 1'b0, '0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);

      // Reset mid-transfer with bit_count=5
      cycle(1'b1, 1'b1, 8'hC3, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, '0, 1'b1);
      chk("pre_reset_count", int'(bit_count), 5);
      cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b1, 8'h55, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 40) != 0, ($urandom % 4) == 0, W'($urandom), ($urandom % 3) != 0);
      end

      // Drain any outstanding operand within a bounded budget
      for (int i = 0; i < 3 * int'(W); i++) begin
         if (sb.size() != 0 || done_pend) cycle(1'b1, 1'b0, '0, 1'b1);
      end
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);
      chk("drain_empty", sb.size(), 0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_serializer.md
Name: operand_serializer

Overview:
Parallel-in, serial-out operand shifter for the sequential multiplier datapath. It captures a WIDTH-bit operand in one cycle, then presents it one bit per Shift strobe on Data_Out. It is the transmit end feeding the single-bit shift register stages of the multiplier, which sample Data_Out on the same Shift-qualified clock edge. Internal FSM and counter track remaining bits and flag completion.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on posedge clk.
rst  input  1  synchronous, active-low reset; sampled only on posedge clk.
load  input  1  request to capture Data_In; honoured in IDLE and DONE only.
Data_In  input  WIDTH  parallel operand.
Shift  input  1  advance strobe; one bit consumed per cycle with Shift=1 in SHIFT state.
Data_Out  output  1  current serial bit (combinational from state/shift register).
busy  output  1  high while in SHIFT state.
done  output  1  single-cycle pulse: all WIDTH bits consumed.
bit_count  output  $clog2(WIDTH+1)  bits still to be shifted out.

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE; shift register=0; bit_count=0; busy=0; done=0; Data_Out=0. Reset has priority over load/Shift and aborts any transfer mid-operation; no done pulse.
- States: IDLE, SHIFT, DONE. Encoded state register, registered outputs busy/done/bit_count.
- IDLE: load=1 -> shift register<=Data_In, bit_count<=WIDTH, next=SHIFT. Shift ignored. Otherwise hold.
- SHIFT: Data_Out = shift register[0] (LSB first, default). Shift=1 -> shift register<=shift register>>1 (zero fill at MSB), bit_count<=bit_count-1; if bit_count==1, next=DONE. Shift=0 -> hold all state; Data_Out stable.
- load during SHIFT: ignored; operand not replaced, bit_count unaffected.
- DONE: done=1 for exactly this one cycle; Data_Out=0; bit_count=0. Next=IDLE, unless load=1 -> capture Data_In, bit_count<=WIDTH, next=SHIFT (back-to-back operands; done still pulses this cycle).
- Data_Out=0 in IDLE and DONE.
- Latency: load accepted at edge N -> first bit valid on Data_Out after edge N; last bit consumed at the WIDTH-th Shift edge; done high in the following cycle.
- Consumer contract: receiver samples Data_Out on the same posedge where Shift=1; serializer updates after that edge, no bubble.
- Counter never wraps: decrement only in SHIFT with bit_count>=1.

Optional Feature:
Macro SERIALIZER_MSB_FIRST_EN.
- Defined: Data_Out = shift register[WIDTH-1]; Shift performs left shift (zero fill at LSB). All timing, counting, done behaviour unchanged.
- Not defined: LSB-first, right shift, as specified above.

Test Plan:
- Reset: drive rst=0 for 2 cycles mid-SHIFT with bit_count=5 -> next cycle busy=0, done=0, bit_count=0, Data_Out=0, state IDLE, no done pulse.
- Basic LSB-first: WIDTH=8, load Data_In=8'hB5, Shift held 1 -> Data_Out sequence 1,0,1,0,1,1,0,1 on 8 consecutive edges; bit_count 8..1; done=1 one cycle after the 8th shift; busy=0 then.
- Stalled Shift: load 8'h3C, toggle Shift 1,0,0,1,... -> Data_Out holds while Shift=0; bit_count decrements only on Shift=1; total 8 Shift-high cycles to done.
- Ignored inputs: Shift=1 in IDLE -> no state change; load 8'hFF during SHIFT of 8'h01 -> output stream still 1,0,0,0,0,0,0,0.
- Back-to-back: load=1 with Data_In=8'hA5 in DONE cycle of previous operand -> done pulses once; next cycle busy=1, bit_count=8, stream 1,0,1,0,0,1,0,1.
- With SERIALIZER_MSB_FIRST_EN: load 8'hB5 -> stream 1,0,1,1,0,1,0,1; done timing identical to LSB-first case.
